glitch_sweep: RTL and testbench
===============================

GLITCH_SWEEP -- requirements
Module: glitch_sweep

Interface
REQ-001 Parameter TIMEOUT_BITS, default 24, sets the width of the per-attempt timeout counter.
REQ-002 Parameter TIMEOUT_CYCLES, default 24'hFFFFFF, is the number of clk cycles allowed in WAIT_DONE before the block requests termination.
REQ-003 clk  in  1  single clock; every register updates on posedge clk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request that launches a sweep; honoured only in IDLE.
REQ-006 abort  in  1  level or pulse that ends the sweep after the current attempt.
REQ-007 delay_start, delay_step  in  32 each  first delay value and delay increment.
REQ-008 length_start, length_step  in  32 each  first length value and length increment.
REQ-009 delay_points, length_points  in  16 each  number of sweep points per axis; 0 is treated as 1.
REQ-010 repeats  in  8  attempts per (delay, length) point; 0 is treated as 1.
REQ-011 slow_armed, slow_done_ack, terminate_slow  out  1 each  handshake outputs to the glitcher.
REQ-012 armed_ack, done  in  1 each  handshake inputs from the glitcher (same clk domain).
REQ-013 delay_out, length_out  out  32 each  parameters applied to the glitcher.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 sweep_done  out  1  one-cycle pulse on entry to IDLE from FINISH.
REQ-016 attempt_count, timeout_count  out  32 each  completed attempts and attempts that ended by timeout or abort, both for the current sweep.

Function
REQ-017 States: IDLE, LOAD, ARM, WAIT_DONE, ACK, NEXT, FINISH.
REQ-018 IDLE->LOAD on start: latch all configuration inputs, set delay_out=delay_start and length_out=length_start, clear the point/repeat indices and both counters.
REQ-019 LOAD->ARM after one cycle; delay_out and length_out stay stable from LOAD until NEXT.
REQ-020 ARM: slow_armed=1 until armed_ack==1 is sampled; then slow_armed=0 in the next cycle and the state moves to WAIT_DONE.
REQ-021 WAIT_DONE: timeout counter increments each cycle; on done==1 -> ACK.
REQ-022 WAIT_DONE: when the timeout counter reaches TIMEOUT_CYCLES, or abort is latched, terminate_slow=1 is held until done==1; timeout_count increments once per attempt so terminated.
REQ-023 ACK: slow_done_ack=1 and terminate_slow=0; ACK->NEXT when done==0 and armed_ack==0; attempt_count increments on that exit.
REQ-024 NEXT: if abort is latched -> FINISH; else advance in this order: repeat index, then length index (length_out+=length_step, repeat reset), then delay index (delay_out+=delay_step, length_out=length_start); when all indices are exhausted -> FINISH; else -> ARM.
REQ-025 Arithmetic: delay_out and length_out wrap modulo 2^32 with no saturation; attempt_count and timeout_count wrap modulo 2^32.
REQ-026 FINISH->IDLE unconditionally after one cycle; sweep_done=1 during that IDLE entry cycle only.
REQ-027 abort is latched in any non-IDLE state and cleared in IDLE; abort in IDLE is ignored.
REQ-028 start outside IDLE is ignored; simultaneous start and abort in IDLE starts the sweep.
REQ-029 When done and timeout occur in the same cycle, done wins: the block goes to ACK and timeout_count is not incremented.
REQ-030 Total attempts equal delay_points*length_points*repeats (each factor at least 1).

Reset
REQ-031 While rst_n==0: state=IDLE; slow_armed, slow_done_ack, terminate_slow, busy and sweep_done are 0; delay_out, length_out, attempt_count and timeout_count are 0; abort latch and indices are cleared.
REQ-032 Reset mid-attempt drops all handshake outputs immediately; no attempt is counted.

Verification
REQ-033 Bench: delay 100/step 10/points 3, length 8/step 4/points 2, repeats 1, glitcher model finishing in 50 cycles -> 6 attempts with (delay,length) sequence (100,8)(100,12)(110,8)(110,12)(120,8)(120,12); attempt_count=6, timeout_count=0, one sweep_done.
REQ-034 Bench: all points 0 and repeats 0 -> exactly 1 attempt at the start values.
REQ-035 Bench: model never raises done until terminate_slow, TIMEOUT_CYCLES=16 -> terminate_slow rises 16 cycles into WAIT_DONE; timeout_count=1 after the sweep.
REQ-036 Bench: abort during the 2nd attempt of a 6-attempt sweep -> terminate_slow asserted, ACK completes, FINISH, attempt_count=2, sweep_done pulse.
REQ-037 Bench: delay_start=32'hFFFFFFF0, step 16, points 2 -> second delay_out=0.
REQ-038 Bench: rst_n low during WAIT_DONE -> all outputs 0 on the same edge; a new start afterwards runs cleanly.

Source files
------------

// File: rtl/glitch_sweep.sv
// rtl/glitch_sweep.sv - delay/length sweep sequencer driving a glitcher through an arm/done handshake
module glitch_sweep #(
   parameter int                      TIMEOUT_BITS   = 24,
   parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] delay_start,
   input  logic [31:0] delay_step,
   input  logic [31:0] length_start,
   input  logic [31:0] length_step,
   input  logic [15:0] delay_points,
   input  logic [15:0] length_points,
   input  logic [7:0]  repeats,
   input  logic        armed_ack,
   input  logic        done,
   output logic        slow_armed,
   output logic        slow_done_ack,
   output logic        terminate_slow,
   output logic [31:0] delay_out,
   output logic [31:0] length_out,
   output logic        busy,
   output logic        sweep_done,
   output logic [31:0] attempt_count,
   output logic [31:0] timeout_count
);

   typedef enum logic [2:0] {IDLE, LOAD, ARM, WAIT_DONE, ACK, NEXT, FINISH} state_t;

   localparam logic [TIMEOUT_BITS-1:0] TMO_ONE = 1;

   state_t                  state;
   logic [31:0]             delay_step_q;
   logic [31:0]             length_start_q;
   logic [31:0]             length_step_q;
   logic [15:0]             delay_last;
   logic [15:0]             length_last;
   logic [7:0]              repeat_last;
   logic [15:0]             delay_idx;
   logic [15:0]             length_idx;
   logic [7:0]              repeat_idx;
   logic [TIMEOUT_BITS-1:0] tmo_cnt;
   logic                    abort_q;
   logic                    abort_now;
   logic                    tmo_hit;

   assign abort_now = abort_q | abort;
   assign tmo_hit   = (tmo_cnt + TMO_ONE) == TIMEOUT_CYCLES;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         slow_armed     <= 1'b0;
         slow_done_ack  <= 1'b0;
         terminate_slow <= 1'b0;
         busy           <= 1'b0;
         sweep_done     <= 1'b0;
         delay_out      <= '0;
         length_out     <= '0;
         attempt_count  <= '0;
         timeout_count  <= '0;
         delay_step_q   <= '0;
         length_start_q <= '0;
         length_step_q  <= '0;
         delay_last     <= '0;
         length_last    <= '0;
         repeat_last    <= '0;
         delay_idx      <= '0;
         length_idx     <= '0;
         repeat_idx     <= '0;
         tmo_cnt        <= '0;
         abort_q        <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         abort_q    <= (state == IDLE) ? 1'b0 : abort_now;
         case (state)
            IDLE: begin
               if (start) begin
                  state          <= LOAD;
                  busy           <= 1'b1;
                  delay_out      <= delay_start;
                  length_out     <= length_start;
                  delay_step_q   <= delay_step;
                  length_start_q <= length_start;
                  length_step_q  <= length_step;
                  // Store last index rather than count so a zero count behaves as one point
                  delay_last     <= (delay_points == 16'd0) ? 16'd0 : delay_points - 16'd1;
                  length_last    <= (length_points == 16'd0) ? 16'd0 : length_points - 16'd1;
                  repeat_last    <= (repeats == 8'd0) ? 8'd0 : repeats - 8'd1;
                  delay_idx      <= '0;
                  length_idx     <= '0;
                  repeat_idx     <= '0;
                  attempt_count  <= '0;
                  timeout_count  <= '0;
               end
            end
            LOAD: begin
               state      <= ARM;
               slow_armed <= 1'b1;
            end
            ARM: begin
               if (armed_ack) begin
                  state      <= WAIT_DONE;
                  slow_armed <= 1'b0;
                  tmo_cnt    <= '0;
               end
            end
            WAIT_DONE: begin
               if (done) begin
                  state          <= ACK;
                  slow_done_ack  <= 1'b1;
                  terminate_slow <= 1'b0;
               end else if (!terminate_slow) begin
                  // Counter freezes once termination is requested; done is all that matters then
                  tmo_cnt <= tmo_cnt + TMO_ONE;
                  if (tmo_hit || abort_now) begin
                     terminate_slow <= 1'b1;
                     timeout_count  <= timeout_count + 32'd1;
                  end
               end
            end
            ACK: begin
               if (!done && !armed_ack) begin
                  state         <= NEXT;
                  slow_done_ack <= 1'b0;
                  attempt_count <= attempt_count + 32'd1;
               end
            end
            NEXT: begin
               if (abort_now) begin
                  state <= FINISH;
               end else if (repeat_idx != repeat_last) begin
                  repeat_idx <= repeat_idx + 8'd1;
                  state      <= ARM;
                  slow_armed <= 1'b1;
               end else if (length_idx != length_last) begin
                  length_idx <= length_idx + 16'd1;
                  repeat_idx <= '0;
                  length_out <= length_out + length_step_q;
                  state      <= ARM;
                  slow_armed <= 1'b1;
               end else if (delay_idx != delay_last) begin
                  delay_idx  <= delay_idx + 16'd1;
                  length_idx <= '0;
                  repeat_idx <= '0;
                  delay_out  <= delay_out + delay_step_q;
                  length_out <= length_start_q;
                  state      <= ARM;
                  slow_armed <= 1'b1;
               end else begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               state      <= IDLE;
               busy       <= 1'b0;
               sweep_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_glitch_sweep.sv
// tb/tb_glitch_sweep.sv - scoreboard bench for glitch_sweep with a behavioural glitcher
module tb_glitch_sweep;

   localparam int TO       = 16;
   localparam int DONE_LAT = 50;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic abort = 1'b0;
   logic start [2];
   logic [31:0] delay_start, delay_step, length_start, length_step;
   logic [15:0] delay_points, length_points;
   logic [7:0]  repeats;
   logic armed_ack [2];
   logic done [2];
   logic slow_armed [2];
   logic slow_done_ack [2];
   logic terminate_slow [2];
   logic busy [2];
   logic sweep_done [2];
   logic [31:0] delay_out [2];
   logic [31:0] length_out [2];
   logic [31:0] attempt_count [2];
   logic [31:0] timeout_count [2];

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   glitch_sweep u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort),
      .delay_start(delay_start), .delay_step(delay_step),
      .length_start(length_start), .length_step(length_step),
      .delay_points(delay_points), .length_points(length_points), .repeats(repeats),
      .armed_ack(armed_ack[0]), .done(done[0]),
      .slow_armed(slow_armed[0]), .slow_done_ack(slow_done_ack[0]), .terminate_slow(terminate_slow[0]),
      .delay_out(delay_out[0]), .length_out(length_out[0]), .busy(busy[0]), .sweep_done(sweep_done[0]),
      .attempt_count(attempt_count[0]), .timeout_count(timeout_count[0])
   );

   glitch_sweep #(.TIMEOUT_BITS(24), .TIMEOUT_CYCLES(24'd16)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort),
      .delay_start(delay_start), .delay_step(delay_step),
      .length_start(length_start), .length_step(length_step),
      .delay_points(delay_points), .length_points(length_points), .repeats(repeats),
      .armed_ack(armed_ack[1]), .done(done[1]),
      .slow_armed(slow_armed[1]), .slow_done_ack(slow_done_ack[1]), .terminate_slow(terminate_slow[1]),
      .delay_out(delay_out[1]), .length_out(length_out[1]), .busy(busy[1]), .sweep_done(sweep_done[1]),
      .attempt_count(attempt_count[1]), .timeout_count(timeout_count[1])
   );

   // Glitcher 0 finishes DONE_LAT cycles after arming; glitcher 1 only answers terminate_slow
   int   wcnt [2];
   logic active [2];
   always @(posedge clk or negedge rst_n) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            armed_ack[g] <= 1'b0;
            done[g]      <= 1'b0;
            active[g]    <= 1'b0;
            wcnt[g]      <= 0;
         end else begin
            armed_ack[g] <= slow_armed[g];
            if (slow_armed[g] && !armed_ack[g]) begin
               active[g] <= 1'b1;
               wcnt[g]   <= 0;
            end else if (active[g]) begin
               wcnt[g] <= wcnt[g] + 1;
               if (terminate_slow[g] || (g == 0 && wcnt[g] == DONE_LAT - 1)) begin
                  done[g]   <= 1'b1;
                  active[g] <= 1'b0;
               end
            end
            if (slow_done_ack[g]) done[g] <= 1'b0;
         end
      end
   end

   task automatic set_cfg(input logic [31:0] ds, input logic [31:0] dst, input logic [15:0] dp,
                          input logic [31:0] ls, input logic [31:0] lst, input logic [15:0] lp,
                          input logic [7:0] r);
      delay_start = ds; delay_step = dst; delay_points = dp;
      length_start = ls; length_step = lst; length_points = lp;
      repeats = r;
   endtask

   task automatic push_grid();
      int dn, ln, rn;
      logic [31:0] dv, lv;
      dn = (delay_points == 0) ? 1 : int'(delay_points);
      ln = (length_points == 0) ? 1 : int'(length_points);
      rn = (repeats == 0) ? 1 : int'(repeats);
      for (int d = 0; d < dn; d++)
         for (int l = 0; l < ln; l++)
            for (int r = 0; r < rn; r++) begin
               dv = delay_start + delay_step * d;
               lv = length_start + length_step * l;
               exp_q.push_back({dv, lv});
            end
   endtask

   task automatic run_sweep(input int inst, input bit abort_start, input int abort_after,
                            output bit finished, output int term_wd);
      bit sa_prev, ts_prev;
      int falls, wd;
      logic [63:0] exp_v, got_v;
      sa_prev = 1'b0; ts_prev = 1'b0; falls = 0; wd = 0; finished = 1'b0; term_wd = -1;
      @(negedge clk); start[inst] = 1'b1; abort = abort_start;
      @(negedge clk); start[inst] = 1'b0; abort = 1'b0;
      for (int i = 0; i < 3000 && !finished; i++) begin
         if (abort) abort = 1'b0;
         got_v = {delay_out[inst], length_out[inst]};
         if (inst == 0 && slow_armed[inst] && !sa_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_extra got %h expected no further attempt", got_v);
            end else begin
               exp_v = exp_q.pop_front();
               if (got_v !== exp_v) begin
                  errors++;
                  $display("FAIL scoreboard_point got %h expected %h", got_v, exp_v);
               end
            end
         end
         if (!slow_armed[inst] && sa_prev) begin
            falls++;
            wd = 0;
            if (falls == abort_after) abort = 1'b1;
         end else begin
            wd++;
         end
         if (terminate_slow[inst] && !ts_prev && term_wd < 0) term_wd = wd;
         if (sweep_done[inst] === 1'b1) finished = 1'b1;
         sa_prev = slow_armed[inst];
         ts_prev = terminate_slow[inst];
         if (!finished) @(negedge clk);
      end
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL sweep_completion got busy=%0b expected sweep_done within bound", busy[inst]);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({slow_armed[k], slow_done_ack[k], terminate_slow[k], busy[k], sweep_done[k]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags dut%0d got %b expected 00000", k,
                     {slow_armed[k], slow_done_ack[k], terminate_slow[k], busy[k], sweep_done[k]});
         end
         checks++;
         if ({delay_out[k], length_out[k], attempt_count[k], timeout_count[k]} !== 128'd0) begin
            errors++;
            $display("FAIL reset_values dut%0d got %h expected 0", k,
                     {delay_out[k], length_out[k], attempt_count[k], timeout_count[k]});
         end
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_basic_grid();
      bit fin; int twd;
      set_cfg(32'd100, 32'd10, 16'd3, 32'd8, 32'd4, 16'd2, 8'd1);
      push_grid();
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      run_sweep(0, 1'b0, 0, fin, twd);
      checks++;
      if (attempt_count[0] !== 32'd6) begin
         errors++; $display("FAIL grid_attempts got %0d expected 6", attempt_count[0]);
      end
      checks++;
      if (timeout_count[0] !== 32'd0) begin
         errors++; $display("FAIL grid_timeouts got %0d expected 0", timeout_count[0]);
      end
      checks++;
      if (busy[0] !== 1'b0 || exp_q.size() != 0) begin
         errors++; $display("FAIL grid_idle got busy=%0b left=%0d expected busy=0 left=0", busy[0], exp_q.size());
      end
      @(negedge clk);
      checks++;
      if (sweep_done[0] !== 1'b0) begin
         errors++; $display("FAIL grid_done_pulse got %0b expected 0", sweep_done[0]);
      end
   endtask

   task automatic test_zero_points();
      bit fin; int twd;
      set_cfg(32'd77, 32'd5, 16'd0, 32'd9, 32'd3, 16'd0, 8'd0);
      push_grid();
      run_sweep(0, 1'b0, 0, fin, twd);
      checks++;
      if (attempt_count[0] !== 32'd1 || exp_q.size() != 0) begin
         errors++; $display("FAIL zero_points got %0d attempts left=%0d expected 1 left=0", attempt_count[0], exp_q.size());
      end
   endtask

   task automatic test_wrap();
      bit fin; int twd;
      set_cfg(32'hFFFFFFF0, 32'd16, 16'd2, 32'd5, 32'd1, 16'd1, 8'd2);
      push_grid();
      run_sweep(0, 1'b0, 0, fin, twd);
      checks++;
      if (delay_out[0] !== 32'd0 || attempt_count[0] !== 32'd4) begin
         errors++; $display("FAIL wrap_delay got delay=%h attempts=%0d expected delay=0 attempts=4", delay_out[0], attempt_count[0]);
      end
   endtask

   task automatic test_timeout();
      bit fin; int twd;
      set_cfg(32'd1, 32'd1, 16'd1, 32'd2, 32'd2, 16'd1, 8'd1);
      run_sweep(1, 1'b0, 0, fin, twd);
      checks++;
      if (twd != TO) begin
         errors++; $display("FAIL timeout_latency got %0d expected %0d", twd, TO);
      end
      checks++;
      if (timeout_count[1] !== 32'd1 || attempt_count[1] !== 32'd1) begin
         errors++; $display("FAIL timeout_counts got tmo=%0d att=%0d expected tmo=1 att=1", timeout_count[1], attempt_count[1]);
      end
      checks++;
      if (terminate_slow[1] !== 1'b0) begin
         errors++; $display("FAIL timeout_release got %0b expected 0", terminate_slow[1]);
      end
   endtask

   task automatic test_abort();
      bit fin; int twd;
      set_cfg(32'd100, 32'd10, 16'd3, 32'd8, 32'd4, 16'd2, 8'd1);
      push_grid();
      run_sweep(0, 1'b0, 2, fin, twd);
      checks++;
      if (twd != 1) begin
         errors++; $display("FAIL abort_terminate got %0d expected 1", twd);
      end
      checks++;
      if (attempt_count[0] !== 32'd2 || timeout_count[0] !== 32'd1) begin
         errors++; $display("FAIL abort_counts got att=%0d tmo=%0d expected att=2 tmo=1", attempt_count[0], timeout_count[0]);
      end
      checks++;
      if (exp_q.size() != 4) begin
         errors++; $display("FAIL abort_remaining got %0d expected 4", exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid();
      bit fin; int twd;
      set_cfg(32'd500, 32'd1, 16'd1, 32'd40, 32'd1, 16'd1, 8'd2);
      @(negedge clk); start[0] = 1'b1;
      @(negedge clk); start[0] = 1'b0;
      for (int i = 0; i < 500 && attempt_count[0] !== 32'd1; i++) @(negedge clk);
      for (int i = 0; i < 500 && slow_armed[0] !== 1'b1; i++) @(negedge clk);
      for (int i = 0; i < 500 && slow_armed[0] !== 1'b0; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      checks++;
      if (attempt_count[0] !== 32'd1 || busy[0] !== 1'b1) begin
         errors++; $display("FAIL midreset_pre got att=%0d busy=%0b expected att=1 busy=1", attempt_count[0], busy[0]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({slow_armed[0], slow_done_ack[0], terminate_slow[0], busy[0], sweep_done[0],
           delay_out[0], length_out[0], attempt_count[0], timeout_count[0]} !== '0) begin
         errors++; $display("FAIL midreset_outputs got delay=%h att=%0d busy=%0b expected all 0", delay_out[0], attempt_count[0], busy[0]);
      end
      @(negedge clk); rst_n = 1'b1;
      set_cfg(32'd3, 32'd0, 16'd1, 32'd4, 32'd0, 16'd1, 8'd1);
      push_grid();
      run_sweep(0, 1'b1, 0, fin, twd);
      checks++;
      if (attempt_count[0] !== 32'd1 || timeout_count[0] !== 32'd0 || exp_q.size() != 0) begin
         errors++; $display("FAIL restart_counts got att=%0d tmo=%0d left=%0d expected 1 0 0", attempt_count[0], timeout_count[0], exp_q.size());
      end
   endtask

   initial begin
      start[0] = 1'b0;
      start[1] = 1'b0;
      set_cfg('0, '0, '0, '0, '0, '0, '0);
      test_reset();
      test_basic_grid();
      test_zero_points();
      test_wrap();
      test_timeout();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
